ofmap_drain: RTL and testbench

Streams finished output-feature-map words out of the core's psum SRAM and requantizes them for the next layer. The block issues psum-SRAM read commands: the CEN_pmem/A_pmem fields that the instruction word carries for the core's psum SRAM. It captures the core's 128-bit `sfp_out` one cycle after each read. Each word's eight 16-bit psums are reduced to eight 4-bit activations, packed into 32-bit words, and sent out on a valid/ready stream toward the activation-memory writer.

---
 rtl/ofmap_drain.sv | 131 +++++++++++++
 tb/tb_ofmap_drain.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ofmap_drain.sv
// Psum SRAM drain: issues reads, requantizes 8x16b psums to 8x4b activations, streams via a 2-deep skid FIFO.
// Optional OFMAP_DRAIN_RELU_EN: ReLU + unsigned [0,15] saturation; otherwise signed [-8,7] saturation.
module ofmap_drain_lane #(
  parameter int psum_bw = 16,
  parameter int bw      = 4
) (
  input  logic [psum_bw-1:0] x,
  input  logic [3:0]         shift,
  output logic [bw-1:0]      y
);
`ifdef OFMAP_DRAIN_RELU_EN
  localparam logic signed [psum_bw-1:0] HI = psum_bw'((2**bw) - 1);
  localparam logic signed [psum_bw-1:0] LO = '0;
`else
  localparam logic signed [psum_bw-1:0] HI = psum_bw'((2**(bw-1)) - 1);
  localparam logic signed [psum_bw-1:0] LO = psum_bw'(-(2**(bw-1)));
`endif
  logic signed [psum_bw-1:0] sh;
  assign sh = $signed(x) >>> shift;

  always_comb begin
    y = sh[bw-1:0];
    if (sh > HI)      y = HI[bw-1:0];
    else if (sh < LO) y = LO[bw-1:0];
  end
endmodule

module ofmap_drain #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int bw      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [10:0]            base_addr,
  input  logic [11:0]            count,
  input  logic [3:0]             shift,
  output logic                   pmem_cen,
  output logic [10:0]            pmem_addr,
  input  logic [col*psum_bw-1:0] sfp_out,
  output logic [col*bw-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 state, nxt;
  logic [10:0]            base_q, addr_q, next_addr;
  logic [11:0]            cnt_q, issued;
  logic [3:0]             shift_q;
  logic                   inflight, issue, pop;
  logic [col*bw-1:0]      mem [2];
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             occ;
  logic [col-1:0][bw-1:0] q_lanes;

  for (genvar i = 0; i < col; i++) begin : g_lane
    ofmap_drain_lane #(.psum_bw(psum_bw), .bw(bw)) u_lane (
      .x     (sfp_out[i*psum_bw +: psum_bw]),
      .shift (shift_q),
      .y     (q_lanes[i])
    );
  end

  assign pop       = out_valid & out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign next_addr = base_q + issued[10:0];

  // Issue only if the word landing next cycle is guaranteed a FIFO slot.
  assign issue     = (state == S_RUN) && (issued != cnt_q) &&
                     (({1'b0, occ} + {2'b0, inflight}) <= (3'd1 + {2'b0, pop}));
  assign pmem_cen  = ~issue;
  assign pmem_addr = issue ? next_addr : addr_q;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = (count == 12'd0) ? S_DONE : S_RUN;
      S_RUN:   if (issued == cnt_q) nxt = S_DRAIN;
      S_DRAIN: if (!inflight && ((occ == 2'd0) || (occ == 2'd1 && pop))) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      issued   <= '0;
      addr_q   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      state    <= nxt;
      inflight <= issue;
      if (state == S_IDLE && start) begin
        base_q  <= base_addr;
        cnt_q   <= count;
        shift_q <= shift;
        issued  <= '0;
      end
      if (issue) begin
        issued <= issued + 12'd1;
        addr_q <= next_addr;
      end
      if (inflight) begin
        mem[wr_ptr] <= q_lanes;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_ofmap_drain.sv
// Scoreboard bench for ofmap_drain: SRAM model pushes expected words on each read, output pops compare.
module tb_ofmap_drain;
  logic         clk = 0, reset = 0, start = 0, out_ready = 1;
  logic [10:0]  base_addr = 0;
  logic [11:0]  count = 0;
  logic [3:0]   shift = 0;
  logic         pmem_cen, out_valid, busy, done;
  logic [10:0]  pmem_addr;
  logic [127:0] sfp_out = 0;
  logic [31:0]  out_data;

  ofmap_drain u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .shift(shift), .pmem_cen(pmem_cen), .pmem_addr(pmem_addr), .sfp_out(sfp_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [127:0] psum [2048];
  always @(posedge clk) if (!pmem_cen) sfp_out <= psum[pmem_addr];

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] q4(input logic [15:0] x, input int sh);
    int y;
    y = int'($signed(x)) >>> sh;
`ifdef OFMAP_DRAIN_RELU_EN
    if (y < 0) y = 0; else if (y > 15) y = 15;
`else
    if (y > 7) y = 7; else if (y < -8) y = -8;
`endif
    return y[3:0];
  endfunction

  function automatic logic [31:0] qword(input logic [127:0] w, input int sh);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = q4(w[16*i +: 16], sh);
    return r;
  endfunction

  logic [31:0] sb[$];
  logic [31:0] prev_data, last_pop_data, exp_sb;
  logic [10:0] exp_addr;
  int          run_shift, reads, pops, first_cen, first_vld, done_cyc, last_pop_cyc, done_cnt = 0;
  bit          stall_prev = 0, tog = 0;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_data", out_data, prev_data);
      end
      if (!pmem_cen) begin
        chk("rd_addr", {21'b0, pmem_addr}, {21'b0, exp_addr});
        sb.push_back(qword(psum[pmem_addr], run_shift));
        exp_addr = exp_addr + 11'd1;
        reads++;
        if (first_cen < 0) first_cen = cyc;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("pop_empty", 32'd1, 32'd0);
        else begin
          exp_sb = sb.pop_front();
          chk("data", out_data, exp_sb);
        end
        last_pop_data = out_data;
        last_pop_cyc  = cyc;
        pops++;
      end
      if (out_valid || !pmem_cen) chk("buffered", sb.size(), 32'd2 - ((sb.size() <= 2) ? 32'd2 - sb.size() : 32'd0));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_busy", {31'b0, busy}, 32'd1);
        chk("done_sb_empty", sb.size(), 32'd0);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (tog) out_ready = ~out_ready;
  end

  task automatic kick(input logic [10:0] b, input logic [11:0] c, input logic [3:0] s, output int sc);
    @(posedge clk); #1;
    base_addr = b; count = c; shift = s; start = 1;
    exp_addr = b; run_shift = s; reads = 0; pops = 0; first_cen = -1; first_vld = -1;
    sc = cyc + 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run(input logic [10:0] b, input logic [11:0] c, input logic [3:0] s);
    int sc, d0, n;
    d0 = done_cnt;
    kick(b, c, s, sc);
    n = 0;
    while (done_cnt == d0 && n < 300) begin @(posedge clk); n++; end
    chk("done_seen", {31'b0, done_cnt != d0}, 32'd1);
    chk("reads", reads, {20'b0, c});
    chk("pops", pops, {20'b0, c});
    if (c == 0) chk("done_lat0", done_cyc - sc, 32'd0);
    else begin
      chk("first_cen", first_cen - sc, 32'd0);
      chk("first_valid", first_vld - sc, 32'd2);
      chk("done_lat", done_cyc - last_pop_cyc, 32'd1);
    end
    @(negedge clk);
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("done_after", {31'b0, done}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cen"},   {31'b0, pmem_cen}, 32'd1);
    chk({tag, "_addr"},  {21'b0, pmem_addr}, 32'd0);
    chk({tag, "_data"},  out_data, 32'd0);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
    chk({tag, "_done"},  {31'b0, done}, 32'd0);
  endtask

  initial begin
    int sc, d0;
    for (int i = 0; i < 2048; i++) psum[i] = {$urandom, $urandom, $urandom, $urandom};
    psum[100] = {16'h8000, 16'h7FFF, 16'h0064, 16'h0010, 16'h000F, 16'h0007, 16'h0000, 16'hFFFD};
    psum[200] = {8{16'h0050}};
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    reset = 1;

    run(11'd5, 12'd4, 4'd0);
    run(11'd100, 12'd1, 4'd0);
`ifdef OFMAP_DRAIN_RELU_EN
    chk("quant_table", last_pop_data, 32'h0FFF_F700);
`else
    chk("quant_table", last_pop_data, 32'h8777_770D);
`endif
    run(11'd200, 12'd1, 4'd4);
    chk("quant_shift4", last_pop_data, 32'h5555_5555);
    run(11'd2046, 12'd4, 4'd1);
    chk("wrap_last_addr", {21'b0, exp_addr}, 32'd2);

    // toggling ready, with a stray start mid-drain that must be ignored
    tog = 1;
    fork
      run(11'd300, 12'd8, 4'd2);
      begin
        repeat (5) @(posedge clk);
        #2 base_addr = 11'd900; count = 12'd3; shift = 4'd7; start = 1;
        @(posedge clk); #2 start = 0;
      end
    join
    tog = 0;
    @(posedge clk); #1 out_ready = 1;

    run(11'd77, 12'd0, 4'd0);
    run(11'd1000, 12'd16, 4'd3);

    // reset mid-drain
    d0 = done_cnt;
    kick(11'd500, 12'd10, 4'd0, sc);
    repeat (4) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1 chk_reset_vals("abort");
    reset = 1;
    repeat (20) @(posedge clk);
    chk("abort_no_done", done_cnt, d0);
    run(11'd600, 12'd5, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp 0", cyc);
    $fatal(1, "timeout");
  end
endmodule
